sm4_req_scheduler: RTL
======================

Name: sm4_req_scheduler

Overview:
- Shares one sm4_encryptor between num_req_p requesters.
- Round-robin arbitration onto the encryptor input handshake (v_i/ready_o).
- Tags each issued group in an in-order tag FIFO and routes each crypt_o result back to the requester that issued it.
- Sequences cache invalidation: stop issuing, drain outstanding work, pulse invalid_cache_i for one cycle, resume.

Parameters:
- num_req_p, 4, number of requesters (≥2).
- max_out_p, 4, tag FIFO depth = max groups in flight inside the encryptor (power of 2).
- group_size_p, 128, from sm4_encryptor_pkg (not overridden locally).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  num_req_p  per-requester request valid.
- req_content_i  in  num_req_p*group_size_p  per-requester plaintext/ciphertext, requester r at slice r.
- req_key_i  in  num_req_p*group_size_p  per-requester key.
- req_decode_i  in  num_req_p  1 = decode.
- req_ready_o  out  num_req_p  one-hot grant; transfer = req_v_i[r] & req_ready_o[r].
- resp_v_o  out  num_req_p  one-hot result valid.
- resp_data_o  out  group_size_p  result data, shared by all requesters.
- resp_yumi_i  in  num_req_p  requester consumes result; legal only while the matching resp_v_o bit is 1.
- flush_i  in  1  request cache invalidation (level; sampled in RUN).
- flush_done_o  out  1  one-cycle pulse when invalidation is issued.
- enc_content_o  out  group_size_p  to encryptor content_i.
- enc_key_o  out  group_size_p  to encryptor key_i.
- enc_decode_o  out  1  to encryptor encode_or_decode_i.
- enc_v_o  out  1  to encryptor v_i.
- enc_ready_i  in  1  from encryptor ready_o.
- enc_crypt_i  in  group_size_p  from encryptor crypt_o.
- enc_v_i  in  1  from encryptor v_o.
- enc_yumi_o  out  1  to encryptor yumi_i.
- enc_invalid_cache_o  out  1  to encryptor invalid_cache_i.
- outstanding_o  out  $clog2(max_out_p+1)  number of tags in FIFO.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (sync, active-high): state RUN, RR pointer 0, FIFO empty, err_o 0.
- Reset values: all handshake outputs 0, flush_done_o 0, enc_invalid_cache_o 0.
- Reset mid-operation drops all in-flight tags. The encryptor shares reset_i with this block.
- FSM states: RUN, DRAIN, INVAL.
  - RUN → DRAIN when flush_i = 1.
  - DRAIN → INVAL when outstanding_o = 0 and no pop is occurring this cycle.
  - INVAL lasts exactly 1 cycle, then → RUN. It drives enc_invalid_cache_o = 1 and flush_done_o = 1.
- Grant eligibility (combinational): a grant is possible only when all hold:
  - state = RUN;
  - FIFO not full (a simultaneous pop does not free a slot);
  - enc_ready_i = 1.
- Grant selection: the first r with req_v_i[r] = 1, searching from the RR pointer upward with wrap.
  - req_ready_o is that one-hot value, else 0.
  - enc_v_o = |req_ready_o.
  - enc_content_o, enc_key_o and enc_decode_o are muxed from the granted requester. They are zero when there is no grant.
- Issue is zero latency: request and encryptor handshake complete in the same cycle.
  - On transfer: push index r into the FIFO and set the RR pointer to (r+1) mod num_req_p.
- Response path:
  - head = FIFO head tag.
  - resp_v_o[head] = enc_v_i & !empty; all other bits 0.
  - resp_data_o = enc_crypt_i.
  - enc_yumi_o = resp_yumi_i[head] & resp_v_o[head]; FIFO pops on enc_yumi_o.
- Results are returned in issue order; the encryptor returns results in order.
- Simultaneous push and pop: outstanding_o is unchanged and the FIFO pointers both advance.
- Pointer wrap: FIFO pointers wrap mod max_out_p; the RR pointer wraps mod num_req_p.
- err_o is set when either occurs:
  - enc_v_i = 1 while the FIFO is empty;
  - any resp_yumi_i bit is 1 without the matching resp_v_o bit.
- Erroneous yumi is ignored, i.e. the FIFO does not pop.
- flush_i asserted in DRAIN or INVAL has no extra effect. If flush_i is still high on returning to RUN, a new flush starts.

Decomposition:
- Put in sm4_encryptor_pkg:
  - sm4_sched_state_e {RUN, DRAIN, INVAL};
  - group_size_p (already present).
- Sub-module sm4_tag_fifo: parameterised width and depth, in-order, with push, pop, full, empty and count. It implements the tag FIFO.
- The round-robin arbiter stays inline.

Test Plan:
- Single request: req_v_i = 0001, content 0x0123456789abcdeffedcba9876543210, key equal to content, decode 0 → enc_v_o in the same cycle.
  - resp_v_o = 0001 with resp_data_o = 0x681edf34d206965e86b3e94f536e4246.
  - outstanding_o goes 1 → 0 on yumi.
- RR order: req_v_i = 1111 held from reset, enc_ready_i = 1 → grants 0, 1, 2, 3, 0 on consecutive cycles. Responses come back to requesters in the same order.
- Backpressure: enc_v_i held at 0 with continuous requests → exactly max_out_p = 4 transfers, then req_ready_o = 0.
  - Then one pop → no grant that cycle, grant on the next cycle.
- Flush with 3 outstanding: flush_i = 1 → no grants while in DRAIN.
  - After the 3rd yumi, exactly one enc_invalid_cache_o / flush_done_o pulse, then grants resume.
- Error and reset: enc_v_i = 1 with the FIFO empty → err_o = 1 and sticky.
  - Reset with 2 outstanding → next cycle outstanding_o = 0, err_o = 0, RR pointer back to requester 0.

Source files
------------

// File: rtl/sm4_encryptor_pkg.sv
// Shared types and constants for the SM4 encryptor and its request scheduler.
//   group_size_p      : width of one plaintext/ciphertext/key group in bits
//   sm4_sched_state_e : scheduler FSM states (RUN, DRAIN, INVAL)
package sm4_encryptor_pkg;

    localparam int group_size_p = 128;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        INVAL = 2'd2
    } sm4_sched_state_e;

endpackage

// File: rtl/sm4_req_scheduler_if.sv
// Requester-side bundle of the SM4 request scheduler.
// Request channel : req_v_i, req_content_i, req_key_i, req_decode_i -> req_ready_o
// Response channel: resp_v_o, resp_data_o <- resp_yumi_i
// The slave modport is the scheduler's view; master is the requesters' view.
interface sm4_req_scheduler_if #(
    parameter int num_req_p = 4
);

    logic [num_req_p-1:0]                                 req_v_i;
    logic [num_req_p*sm4_encryptor_pkg::group_size_p-1:0] req_content_i;
    logic [num_req_p*sm4_encryptor_pkg::group_size_p-1:0] req_key_i;
    logic [num_req_p-1:0]                                 req_decode_i;
    logic [num_req_p-1:0]                                 req_ready_o;
    logic [num_req_p-1:0]                                 resp_v_o;
    logic [sm4_encryptor_pkg::group_size_p-1:0]           resp_data_o;
    logic [num_req_p-1:0]                                 resp_yumi_i;

    modport slave (
        input  req_v_i,
        input  req_content_i,
        input  req_key_i,
        input  req_decode_i,
        output req_ready_o,
        output resp_v_o,
        output resp_data_o,
        input  resp_yumi_i
    );

    modport master (
        output req_v_i,
        output req_content_i,
        output req_key_i,
        output req_decode_i,
        input  req_ready_o,
        input  resp_v_o,
        input  resp_data_o,
        output resp_yumi_i
    );

endinterface

// File: rtl/sm4_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each group in flight.
// Ports: clk_i, reset_i (sync, active-high), push_i/data_i (write),
//        pop_i (read advance), data_o (head), full_o, empty_o, count_o.
// A push while full or a pop while empty is ignored. depth_p must be a
// power of two so the pointers wrap by natural overflow.
module sm4_tag_fifo #(
    parameter int width_p = 2,
    parameter int depth_p = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           push_i,
    input  logic [width_p-1:0]             data_i,
    input  logic                           pop_i,
    output logic [width_p-1:0]             data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(depth_p+1)-1:0]   count_o
);

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [width_p-1:0]  mem_r [depth_p];
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                push_ok_s;
    logic                pop_ok_s;

    assign full_o    = (count_r == cnt_w_lp'(depth_p));
    assign empty_o   = (count_r == {cnt_w_lp{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_r[rd_ptr_r];
    assign count_o   = count_r;

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= {ptr_w_lp{1'b0}};
            rd_ptr_r <= {ptr_w_lp{1'b0}};
            count_r  <= {cnt_w_lp{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/sm4_req_scheduler.sv
// Shares one SM4 encryptor between num_req_p requesters.
// Ports: clk_i, reset_i (sync, active-high); req_if (requester request and
//        response channels); flush_i / flush_done_o (cache invalidation
//        sequencing); enc_* (encryptor handshake, data and invalidate);
//        outstanding_o (groups in flight); err_o (sticky protocol error).
// Requests are granted round-robin with zero latency straight onto the
// encryptor input. The issuing requester index is queued in a tag FIFO so
// in-order results can be steered back to it.
module sm4_req_scheduler
    import sm4_encryptor_pkg::*;
#(
    parameter int num_req_p = 4,
    parameter int max_out_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    sm4_req_scheduler_if.slave               req_if,
    input  logic                             flush_i,
    output logic                             flush_done_o,
    output logic [group_size_p-1:0]          enc_content_o,
    output logic [group_size_p-1:0]          enc_key_o,
    output logic                             enc_decode_o,
    output logic                             enc_v_o,
    input  logic                             enc_ready_i,
    input  logic [group_size_p-1:0]          enc_crypt_i,
    input  logic                             enc_v_i,
    output logic                             enc_yumi_o,
    output logic                             enc_invalid_cache_o,
    output logic [$clog2(max_out_p+1)-1:0]   outstanding_o,
    output logic                             err_o
);

    localparam int idx_w_lp = $clog2(num_req_p);
    localparam int cnt_w_lp = $clog2(max_out_p + 1);

    sm4_sched_state_e        state_r;
    sm4_sched_state_e        state_n_s;
    logic [idx_w_lp-1:0]     rr_r;
    logic                    err_r;

    logic                    can_issue_s;
    logic                    found_s;
    int                      cand_s;
    logic [idx_w_lp-1:0]     cand_idx_s;
    logic [num_req_p-1:0]    grant_s;
    logic [idx_w_lp-1:0]     grant_idx_s;
    logic                    push_s;
    logic [group_size_p-1:0] content_s;
    logic [group_size_p-1:0] key_s;
    logic                    decode_s;

    logic [idx_w_lp-1:0]     head_s;
    logic                    full_s;
    logic                    empty_s;
    logic [cnt_w_lp-1:0]     count_s;
    logic [num_req_p-1:0]    resp_v_s;
    logic                    pop_s;
    logic                    bad_yumi_s;
    logic                    orphan_s;

    // A slot freed by a same-cycle pop is deliberately not reused
    assign can_issue_s = (state_r == RUN) && !full_s && enc_ready_i;

    // Round-robin pick: first valid requester at or above rr_r, with wrap
    always_comb begin
        grant_s     = {num_req_p{1'b0}};
        grant_idx_s = {idx_w_lp{1'b0}};
        found_s     = 1'b0;
        cand_s      = 0;
        cand_idx_s  = {idx_w_lp{1'b0}};
        for (int k = 0; k < num_req_p; k++) begin
            cand_s     = (int'(rr_r) + k >= num_req_p) ? (int'(rr_r) + k - num_req_p)
                                                       : (int'(rr_r) + k);
            cand_idx_s = idx_w_lp'(cand_s);
            if (can_issue_s && !found_s && req_if.req_v_i[cand_idx_s]) begin
                found_s                 = 1'b1;
                grant_s[cand_idx_s]     = 1'b1;
                grant_idx_s             = cand_idx_s;
            end else begin
                found_s                 = found_s;
            end
        end
    end

    assign push_s = |grant_s;

    // Encryptor input mux; AND-OR form yields zeros when nothing is granted
    always_comb begin
        content_s = {group_size_p{1'b0}};
        key_s     = {group_size_p{1'b0}};
        decode_s  = 1'b0;
        for (int r = 0; r < num_req_p; r++) begin
            content_s = content_s | (req_if.req_content_i[r*group_size_p +: group_size_p]
                                     & {group_size_p{grant_s[r]}});
            key_s     = key_s | (req_if.req_key_i[r*group_size_p +: group_size_p]
                                 & {group_size_p{grant_s[r]}});
            decode_s  = decode_s | (req_if.req_decode_i[r] & grant_s[r]);
        end
    end

    sm4_tag_fifo #(
        .width_p (idx_w_lp),
        .depth_p (max_out_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .data_i  (grant_idx_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Steer an encryptor result to the requester at the FIFO head
    always_comb begin
        resp_v_s = {num_req_p{1'b0}};
        if (enc_v_i && !empty_s) begin
            resp_v_s[head_s] = 1'b1;
        end else begin
            resp_v_s = {num_req_p{1'b0}};
        end
    end

    assign pop_s      = req_if.resp_yumi_i[head_s] & resp_v_s[head_s];
    assign bad_yumi_s = |(req_if.resp_yumi_i & ~resp_v_s);
    assign orphan_s   = enc_v_i & empty_s;

    // Flush sequencing: stop issue, wait for an empty FIFO, invalidate once
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            RUN: begin
                if (flush_i) begin
                    state_n_s = DRAIN;
                end else begin
                    state_n_s = RUN;
                end
            end
            DRAIN: begin
                if (empty_s && !pop_s) begin
                    state_n_s = INVAL;
                end else begin
                    state_n_s = DRAIN;
                end
            end
            INVAL:   state_n_s = RUN;
            default: state_n_s = RUN;
        endcase
    end

    // State, round-robin pointer and sticky error registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= RUN;
            rr_r    <= {idx_w_lp{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            if (push_s) begin
                rr_r <= (grant_idx_s == idx_w_lp'(num_req_p - 1)) ? {idx_w_lp{1'b0}}
                                                                  : grant_idx_s + idx_w_lp'(1);
            end
            err_r <= err_r | bad_yumi_s | orphan_s;
        end
    end

    assign req_if.req_ready_o  = grant_s;
    assign req_if.resp_v_o     = resp_v_s;
    assign req_if.resp_data_o  = enc_crypt_i;

    assign enc_v_o             = push_s;
    assign enc_content_o       = content_s;
    assign enc_key_o           = key_s;
    assign enc_decode_o        = decode_s;
    assign enc_yumi_o          = pop_s;
    assign enc_invalid_cache_o = (state_r == INVAL);
    assign flush_done_o        = (state_r == INVAL);
    assign outstanding_o       = count_s;
    assign err_o               = err_r;

endmodule
